// File: rtl/rram_train_ctrl.sv
// RRAM 6x6 crossbar train controller: SET forming sweep and forward/label/backprop training loop.
// Latency: accepted set/learn shows on the registered outputs 1 cycle later; all outputs are registered.
// Backpressure: none; set/learn arriving while busy are dropped, not queued.
// Optional build macro RRAM_VERIFY_EN adds a one-cycle per-row VERIFY read-back after SET (i_sense/o_verify_fail).
module rram_train_ctrl #(
    parameter int N_ROWS       = 6,
    parameter int SET_CYCLES   = 4,
    parameter int FWD_CYCLES   = 2,
    parameter int LABEL_CYCLES = 1,
    parameter int BACK_CYCLES  = 4,
    parameter int TRAIN_NUM    = 5
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_set,
    input  logic              i_learn,
    input  logic [N_ROWS-1:0] i_pattern,
`ifdef RRAM_VERIFY_EN
    input  logic [N_ROWS-1:0] i_sense,
    output logic              o_verify_fail,
`endif
    output logic [N_ROWS-1:0] o_wl,
    output logic [N_ROWS-1:0] o_sl,
    output logic [N_ROWS-1:0] o_bl,
    output logic              o_dset,
    output logic              o_dback,
    output logic              o_dlabel,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_formed,
    output logic [7:0]        o_train_cnt
);

    localparam int ROW_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam int CNT_W = 8;

    localparam logic [ROW_W-1:0]  LAST_ROW    = ROW_W'(N_ROWS - 1);
    localparam logic [CNT_W-1:0]  SET_LAST    = CNT_W'(SET_CYCLES - 1);
    localparam logic [CNT_W-1:0]  FWD_LAST    = CNT_W'(FWD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  LABEL_LAST  = CNT_W'(LABEL_CYCLES - 1);
    localparam logic [CNT_W-1:0]  BACK_LAST   = CNT_W'(BACK_CYCLES - 1);
    localparam logic [7:0]        LAST_SAMPLE = 8'(TRAIN_NUM - 1);
    localparam logic [N_ROWS-1:0] ALL_ONES    = {N_ROWS{1'b1}};
    localparam logic [N_ROWS-1:0] ROW_ONE     = N_ROWS'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SET_ROW = 3'd1,
        S_FWD     = 3'd2,
        S_LABEL   = 3'd3,
        S_BACK    = 3'd4,
        S_DONE    = 3'd5
`ifdef RRAM_VERIFY_EN
        ,
        S_VERIFY  = 3'd6
`endif
    } state_t;

    // Current state and bookkeeping registers
    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ROW_W-1:0]  r_row;
    logic [7:0]        r_sample;
    logic [N_ROWS-1:0] r_pattern;
    logic              r_formed;
    logic [7:0]        r_train_cnt;

    // Next-state values
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [ROW_W-1:0]  w_row_nxt;
    logic [7:0]        w_sample_nxt;
    logic [N_ROWS-1:0] w_pattern_nxt;
    logic              w_formed_nxt;
    logic [7:0]        w_train_cnt_nxt;

    // Next output values, decoded from the next state so the registered outputs line up with it
    logic [N_ROWS-1:0] w_onehot;
    logic [N_ROWS-1:0] w_wl_nxt;
    logic [N_ROWS-1:0] w_sl_nxt;
    logic [N_ROWS-1:0] w_bl_nxt;
    logic              w_dset_nxt;
    logic              w_dback_nxt;
    logic              w_dlabel_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;

`ifdef RRAM_VERIFY_EN
    logic r_verify_fail;
    logic w_verify_fail_nxt;
`endif

    // State register plus phase/row/sample counters and latched sample pattern
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_row       <= '0;
            r_sample    <= '0;
            r_pattern   <= '0;
            r_formed    <= 1'b0;
            r_train_cnt <= '0;
`ifdef RRAM_VERIFY_EN
            r_verify_fail <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_row       <= w_row_nxt;
            r_sample    <= w_sample_nxt;
            r_pattern   <= w_pattern_nxt;
            r_formed    <= w_formed_nxt;
            r_train_cnt <= w_train_cnt_nxt;
`ifdef RRAM_VERIFY_EN
            r_verify_fail <= w_verify_fail_nxt;
`endif
        end
    end

    // Next-state logic: phase sequencing, row/sample stepping, command acceptance in IDLE only
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_row_nxt       = r_row;
        w_sample_nxt    = r_sample;
        w_pattern_nxt   = r_pattern;
        w_formed_nxt    = r_formed;
        w_train_cnt_nxt = r_train_cnt;
`ifdef RRAM_VERIFY_EN
        w_verify_fail_nxt = r_verify_fail;
`endif
        case (r_state)
            S_IDLE: begin
                // set has priority over learn; learn needs a formed array
                if (i_set) begin
                    w_state_nxt = S_SET_ROW;
                    w_row_nxt   = '0;
                    w_cnt_nxt   = '0;
`ifdef RRAM_VERIFY_EN
                    w_verify_fail_nxt = 1'b0;
`endif
                end else if (i_learn && r_formed) begin
                    w_state_nxt     = S_FWD;
                    w_sample_nxt    = '0;
                    w_train_cnt_nxt = '0;
                    w_cnt_nxt       = '0;
                    w_pattern_nxt   = i_pattern;
                end
            end
            S_SET_ROW: begin
                if (r_cnt == SET_LAST) begin
                    w_cnt_nxt = '0;
`ifdef RRAM_VERIFY_EN
                    w_state_nxt = S_VERIFY;
`else
                    if (r_row == LAST_ROW) begin
                        w_state_nxt  = S_DONE;
                        w_formed_nxt = 1'b1;
                    end else begin
                        w_row_nxt = r_row + ROW_W'(1);
                    end
`endif
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
`ifdef RRAM_VERIFY_EN
            S_VERIFY: begin
                // A weak cell is recorded but the sweep carries on
                if (i_sense != ALL_ONES) begin
                    w_verify_fail_nxt = 1'b1;
                end
                if (r_row == LAST_ROW) begin
                    w_state_nxt  = S_DONE;
                    w_formed_nxt = 1'b1;
                end else begin
                    w_state_nxt = S_SET_ROW;
                    w_row_nxt   = r_row + ROW_W'(1);
                end
            end
`endif
            S_FWD: begin
                if (r_cnt == FWD_LAST) begin
                    w_state_nxt = S_LABEL;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_LABEL: begin
                if (r_cnt == LABEL_LAST) begin
                    w_state_nxt = S_BACK;
                    w_cnt_nxt   = '0;
                    w_row_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_BACK: begin
                if (r_cnt == BACK_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_row == LAST_ROW) begin
                        w_train_cnt_nxt = r_train_cnt + 8'd1;
                        if (r_sample == LAST_SAMPLE) begin
                            w_state_nxt = S_DONE;
                        end else begin
                            // Next sample: its pattern is captured on FWD entry
                            w_state_nxt   = S_FWD;
                            w_sample_nxt  = r_sample + 8'd1;
                            w_pattern_nxt = i_pattern;
                        end
                    end else begin
                        w_row_nxt = r_row + ROW_W'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode for the state being entered; wl/sl only move when state or row changes
    always_comb begin
        w_onehot     = ROW_ONE << w_row_nxt;
        w_wl_nxt     = '0;
        w_sl_nxt     = '0;
        w_bl_nxt     = '0;
        w_dset_nxt   = 1'b0;
        w_dback_nxt  = 1'b0;
        w_dlabel_nxt = 1'b0;
        w_done_nxt   = 1'b0;
        w_busy_nxt   = (w_state_nxt != S_IDLE);
        case (w_state_nxt)
            S_SET_ROW: begin
                w_wl_nxt   = w_onehot;
                w_bl_nxt   = ALL_ONES;
                w_dset_nxt = 1'b1;
            end
`ifdef RRAM_VERIFY_EN
            S_VERIFY: begin
                w_wl_nxt = w_onehot;
            end
`endif
            S_FWD: begin
                w_wl_nxt = ALL_ONES;
                w_bl_nxt = w_pattern_nxt;
            end
            S_LABEL: begin
                w_dlabel_nxt = 1'b1;
            end
            S_BACK: begin
                w_wl_nxt    = w_onehot;
                w_sl_nxt    = w_onehot;
                w_bl_nxt    = w_pattern_nxt;
                w_dback_nxt = 1'b1;
            end
            S_DONE: begin
                w_done_nxt = 1'b1;
            end
            default: begin
                w_wl_nxt = '0;
            end
        endcase
    end

    // Registered array drives and strobes
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_wl     <= '0;
            o_sl     <= '0;
            o_bl     <= '0;
            o_dset   <= 1'b0;
            o_dback  <= 1'b0;
            o_dlabel <= 1'b0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            o_wl     <= w_wl_nxt;
            o_sl     <= w_sl_nxt;
            o_bl     <= w_bl_nxt;
            o_dset   <= w_dset_nxt;
            o_dback  <= w_dback_nxt;
            o_dlabel <= w_dlabel_nxt;
            o_busy   <= w_busy_nxt;
            o_done   <= w_done_nxt;
        end
    end

    assign o_formed    = r_formed;
    assign o_train_cnt = r_train_cnt;
`ifdef RRAM_VERIFY_EN
    assign o_verify_fail = r_verify_fail;
`endif

endmodule

// File: tb/tb_rram_train_ctrl.sv
// Bench for rram_train_ctrl: command-level model expands each accepted command into its cycle trace.
// A monitor pops one expected output vector per cycle and compares it with the DUT.
// Random patterns, random idle gaps, random ignored commands while busy, and an async reset mid-training.
module tb_rram_train_ctrl;

    typedef struct packed {
        logic [5:0] wl;
        logic [5:0] sl;
        logic [5:0] bl;
        logic       dset;
        logic       dback;
        logic       dlabel;
        logic       busy;
        logic       done;
        logic       formed;
        logic [7:0] train_cnt;
    } vec_t;

    typedef struct {
        vec_t       v;
        logic [5:0] pat;
    } item_t;

    logic       clk;
    logic       i_reset;
    logic       i_set;
    logic       i_learn;
    logic [5:0] i_pattern;
    logic [5:0] o_wl;
    logic [5:0] o_sl;
    logic [5:0] o_bl;
    logic       o_dset;
    logic       o_dback;
    logic       o_dlabel;
    logic       o_busy;
    logic       o_done;
    logic       o_formed;
    logic [7:0] o_train_cnt;
`ifdef RRAM_VERIFY_EN
    logic [5:0] i_sense;
    logic       o_verify_fail;
`endif

    rram_train_ctrl dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_set       (i_set),
        .i_learn     (i_learn),
        .i_pattern   (i_pattern),
`ifdef RRAM_VERIFY_EN
        .i_sense     (i_sense),
        .o_verify_fail(o_verify_fail),
`endif
        .o_wl        (o_wl),
        .o_sl        (o_sl),
        .o_bl        (o_bl),
        .o_dset      (o_dset),
        .o_dback     (o_dback),
        .o_dlabel    (o_dlabel),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_formed    (o_formed),
        .o_train_cnt (o_train_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc      = 0;
    vec_t       exp_q[$];
    item_t      plan[$];
    logic       m_formed;
    logic [7:0] m_train_cnt;
    bit         fixed_pat;
    logic [5:0] one6 = 6'd1;

    function automatic vec_t dut_vec();
        vec_t v;
        v.wl = o_wl; v.sl = o_sl; v.bl = o_bl;
        v.dset = o_dset; v.dback = o_dback; v.dlabel = o_dlabel;
        v.busy = o_busy; v.done = o_done; v.formed = o_formed;
        v.train_cnt = o_train_cnt;
        return v;
    endfunction

    task automatic check_vec(input string name, input vec_t got, input vec_t exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got wl=%b sl=%b bl=%b dset=%b dback=%b dlabel=%b busy=%b done=%b formed=%b cnt=%0d | required wl=%b sl=%b bl=%b dset=%b dback=%b dlabel=%b busy=%b done=%b formed=%b cnt=%0d",
                     name, got.wl, got.sl, got.bl, got.dset, got.dback, got.dlabel, got.busy, got.done, got.formed, got.train_cnt,
                     exp.wl, exp.sl, exp.bl, exp.dset, exp.dback, exp.dlabel, exp.busy, exp.done, exp.formed, exp.train_cnt);
        end
    endtask

    // Monitor: one expected vector per cycle, compared away from the rising edge
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() > 0) begin
                vec_t e;
                e = exp_q.pop_front();
                check_vec($sformatf("cyc%0d", cyc), dut_vec(), e);
            end
        end
    end

    function automatic vec_t base_vec();
        vec_t v;
        v = '0;
        v.formed    = m_formed;
        v.train_cnt = m_train_cnt;
        return v;
    endfunction

    task automatic push(input vec_t v, input logic [5:0] p);
        item_t it;
        it.v   = v;
        it.pat = p;
        plan.push_back(it);
    endtask

    // SET sweep: each row held SET_CYCLES with all bitlines, then done, then back to idle
    task automatic gen_set();
        vec_t v;
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 4; c++) begin
                v = base_vec();
                v.wl = one6 << r; v.bl = 6'h3F; v.dset = 1'b1; v.busy = 1'b1;
                push(v, 6'($urandom));
            end
`ifdef RRAM_VERIFY_EN
            v = base_vec();
            v.wl = one6 << r; v.busy = 1'b1;
            push(v, 6'($urandom));
`endif
        end
        m_formed = 1'b1;
        v = base_vec(); v.done = 1'b1; v.busy = 1'b1;
        push(v, 6'($urandom));
        push(base_vec(), 6'($urandom));
    endtask

    // Training: per sample 2 forward, 1 label, 6 rows x 4 backprop cycles
    task automatic gen_learn(input bit fixed);
        vec_t       v;
        logic [5:0] pats[5];
        m_train_cnt = 8'd0;
        for (int s = 0; s < 5; s++) pats[s] = fixed ? 6'b101101 : 6'($urandom);
        for (int s = 0; s < 5; s++) begin
            for (int c = 0; c < 2; c++) begin
                v = base_vec(); v.wl = 6'h3F; v.bl = pats[s]; v.busy = 1'b1;
                push(v, (c == 0) ? pats[s] : 6'($urandom));
            end
            v = base_vec(); v.dlabel = 1'b1; v.busy = 1'b1;
            push(v, 6'($urandom));
            for (int r = 0; r < 6; r++) begin
                for (int c = 0; c < 4; c++) begin
                    v = base_vec();
                    v.wl = one6 << r; v.sl = one6 << r; v.bl = pats[s];
                    v.dback = 1'b1; v.busy = 1'b1;
                    push(v, 6'($urandom));
                end
            end
            m_train_cnt++;
        end
        v = base_vec(); v.done = 1'b1; v.busy = 1'b1;
        push(v, 6'($urandom));
        push(base_vec(), 6'($urandom));
    endtask

    // One clock: commands are only accepted when the model has nothing in flight
    task automatic step(input bit s, input bit l);
        item_t it;
        if (plan.size() == 0) begin
            if (s) gen_set();
            else if (l && m_formed) gen_learn(fixed_pat);
            if (plan.size() == 0) push(base_vec(), 6'($urandom));
        end
        it = plan.pop_front();
        i_set     = s;
        i_learn   = l;
        i_pattern = it.pat;
        @(posedge clk);
        #1;
        exp_q.push_back(it.v);
        i_set   = 1'b0;
        i_learn = 1'b0;
    endtask

    // Run the current command to completion, throwing stray commands at the busy DUT
    task automatic drain();
        while (plan.size() > 0) begin
            step($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
        end
    endtask

    task automatic mid_reset();
        #1;
        i_reset = 1'b0;
        #1;
        exp_q.delete();
        plan.delete();
        m_formed    = 1'b0;
        m_train_cnt = 8'd0;
        check_vec("async_reset", dut_vec(), '0);
        repeat (2) @(posedge clk);
        #1;
        i_reset = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset = 1'b0; i_set = 1'b0; i_learn = 1'b0; i_pattern = '0;
`ifdef RRAM_VERIFY_EN
        i_sense = 6'h3F;
`endif
        m_formed = 1'b0; m_train_cnt = 8'd0; fixed_pat = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_vec("reset_state", dut_vec(), '0);
        i_reset = 1'b1;

        // learn before forming is ignored
        step(0, 0); step(0, 1); step(0, 0); step(0, 0);

        // forming sweep, then training with the fixed pattern
        step(1, 0); drain();
        step(0, 0);
        step(0, 1); drain();

        // set and learn together: set wins
        fixed_pat = 1'b0;
        step(0, 0);
        step(1, 1); drain();

        // random command mix with random gaps
        for (int i = 0; i < 12; i++) begin
            int k;
            repeat ($urandom_range(0, 3)) step(0, 0);
            k = $urandom_range(0, 2);
            step(k != 1, k != 0);
            drain();
        end

        // reset part-way through training
        step(0, 1);
        repeat (40) step(0, 0);
        mid_reset();
        step(0, 1); step(0, 0); step(0, 0);
        step(1, 0); drain();
        step(0, 1); drain();
        step(0, 0);

        repeat (2) @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rram_train_ctrl.md
Name: rram_train_ctrl

Overview:
- Device-side controller for the 6x6 RRAM crossbar, driven by the `set` and `learn` command pulses from the system sequencer.
- `set` runs a row-by-row SET (forming) sweep of the array.
- `learn` runs TRAIN_NUM training iterations. Each iteration is a forward read, a label phase and a row-by-row backprop write.
- The block drives wordline, sourceline and bitline enables plus phase strobes to the analog array drivers.

Parameters:
- N_ROWS, 6: rows/columns of the crossbar; sets the width of wl/sl/bl.
- SET_CYCLES, 4: cycles each row is held in SET.
- FWD_CYCLES, 2: forward-read cycles per sample.
- LABEL_CYCLES, 1: label-phase cycles per sample.
- BACK_CYCLES, 4: backprop cycles per row.
- TRAIN_NUM, 5: samples per learn command.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- set  in  1  one-cycle command pulse: start SET sweep.
- learn  in  1  one-cycle command pulse: start training.
- pattern  in  N_ROWS  input sample, latched at each FWD entry.
- wl  out  N_ROWS  wordline enables.
- sl  out  N_ROWS  sourceline enables.
- bl  out  N_ROWS  bitline enables.
- dset  out  1  SET phase strobe.
- dback  out  1  backprop phase strobe.
- dlabel  out  1  label phase strobe.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- formed  out  1  array has completed at least one SET sweep since reset.
- train_cnt  out  8  samples completed in the current/last learn run.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs go to 0, including formed and train_cnt.
  - State goes to IDLE and all counters clear.
  - Reset mid-sweep or mid-training aborts with no done pulse.
- States: IDLE, SET_ROW, FWD, LABEL, BACK, DONE.
- All outputs are registered; command response latency is 1 cycle.
- IDLE:
  - wl=sl=bl=0 and all strobes 0.
  - set=1 → SET_ROW, row=0.
  - learn=1 with formed=1 → FWD, sample=0, train_cnt=0.
  - learn with formed=0 is ignored.
  - set and learn in the same cycle: set wins.
- While busy=1, set and learn are ignored (no queuing).
- SET_ROW:
  - wl=onehot(row), sl=0, bl=all ones, dset=1, held SET_CYCLES cycles.
  - row increments; after row N_ROWS-1 → DONE and formed←1.
- FWD:
  - Latch pattern on entry.
  - wl=all ones, sl=0, bl=latched pattern, for FWD_CYCLES cycles → LABEL.
- LABEL: dlabel=1, wl=sl=bl=0, for LABEL_CYCLES cycles → BACK with row=0.
- BACK:
  - wl=onehot(row), sl=onehot(row), bl=latched pattern, dback=1, for BACK_CYCLES cycles per row.
  - After row N_ROWS-1: train_cnt+1.
  - If sample==TRAIN_NUM-1 → DONE, else → FWD with sample+1.
- DONE: done=1 and busy=1 for exactly one cycle, all drives 0 → IDLE.
- Strobe and enable invariants:
  - At most one of dset/dback/dlabel is high at any time.
  - wl/sl change only on phase or row boundaries.
  - train_cnt holds its value after DONE until the next accepted learn.
- Cycle counts with defaults, accepted command at edge k:
  - SET: dset high k+1..k+24, done at k+25.
  - Learn: 27 cycles per sample; done at k+136.

Optional Feature:
- Macro: RRAM_VERIFY_EN.
- When defined, the following are added:
  - Input sense[N_ROWS-1:0].
  - Output verify_fail (1 bit, reset 0, sticky until reset or next accepted set).
  - A one-cycle VERIFY state after each SET_ROW row: wl=onehot(row), bl=0, sl=0, strobes 0.
- In VERIFY, if sense != all ones, verify_fail←1; the sweep continues regardless.
- SET done moves to k+1+N_ROWS*(SET_CYCLES+1), i.e. k+31 with defaults.
- When undefined, there is no sense/verify_fail port and no VERIFY state; timing is as above.

Test Plan:
- Reset low 2 cycles, then high; pulse learn → no busy, formed=0, train_cnt=0, all drives 0.
- Pulse set at edge k:
  - wl=000001 k+1..k+4, then 000010, and so on up to 100000 at k+21..k+24.
  - bl=111111 and dset=1 throughout.
  - done=1 only at k+25; formed=1 after.
- After forming, pattern=6'b101101, pulse learn:
  - FWD: wl=111111, bl=101101 for 2 cycles.
  - LABEL: dlabel for 1 cycle.
  - BACK: wl=sl=onehot per row for 4 cycles each.
  - train_cnt counts 1..5; done at k+136.
- During training, pulse set and learn → ignored; the sequence and done time are unchanged.
- Set and learn in the same IDLE cycle → SET sweep runs; no training.
- Reset low at cycle 40 of training → all outputs 0 immediately, no done; formed=0; a subsequent learn is ignored.
- With RRAM_VERIFY_EN:
  - sense=111111 → verify_fail=0, done at k+31.
  - sense=111011 during row-2 VERIFY → verify_fail=1 persists until reset or next set.
